// File: rtl/vga_axil_pkg.sv
// Shared AXI4-Lite types and constants for the VGA register interface.
package vga_axil_pkg;

    localparam int AXIL_ADDR_W       = 32;
    localparam int AXIL_DATA_W       = 32;
    localparam int AXIL_STRB_W       = AXIL_DATA_W / 8;
    localparam int VGA_AXIL_ADDR_LSB = 2;

    typedef logic [AXIL_ADDR_W-1:0] axil_addr_t;
    typedef logic [AXIL_DATA_W-1:0] axil_data_t;
    typedef logic [AXIL_STRB_W-1:0] axil_strb_t;

    typedef enum logic [1:0] {
        AXIL_OKAY   = 2'b00,
        AXIL_SLVERR = 2'b10
    } axil_resp_e;

    typedef enum logic [1:0] {
        WR_IDLE,
        WR_GOT_AW,
        WR_GOT_W,
        WR_RESP
    } wr_state_e;

endpackage

// File: rtl/vga_axil_slave_wr.sv
// AXI4-Lite write channel: AW/W capture in either order, decode, B response.
// o_commit fires combinationally on the edge that enters RESP for a legal write.
module vga_axil_slave_wr
    import vga_axil_pkg::*;
#(
    parameter int                  NUM_REGS = 4,
    parameter logic [NUM_REGS-1:0] RO_MASK  = 4'b1000,
    parameter int                  IDX_W    = 2
) (
    input  logic             clk,
    input  logic             i_srst,
    input  axil_addr_t       i_awaddr,
    input  logic             i_awvalid,
    output logic             o_awready,
    input  axil_data_t       i_wdata,
    input  axil_strb_t       i_wstrb,
    input  logic             i_wvalid,
    output logic             o_wready,
    output axil_resp_e       o_bresp,
    output logic             o_bvalid,
    input  logic             i_bready,
    output logic             o_commit,
    output logic [IDX_W-1:0] o_idx,
    output axil_data_t       o_data,
    output axil_strb_t       o_strb
);

    wr_state_e  r_state;
    logic       r_awready;
    logic       r_wready;
    logic       r_bvalid;
    axil_resp_e r_bresp;
    axil_addr_t r_addr;
    axil_data_t r_data;
    axil_strb_t r_strb;

    logic       w_aw_hs;
    logic       w_w_hs;
    logic       w_enter_resp;
    logic       w_err;
    axil_addr_t w_addr;
    axil_addr_t w_word;

    assign w_aw_hs = i_awvalid & r_awready;
    assign w_w_hs  = i_wvalid & r_wready;

    // Whichever half arrived earlier comes from the latch, the other live from the bus.
    assign w_addr = (r_state == WR_GOT_AW) ? r_addr : i_awaddr;
    assign o_data = (r_state == WR_GOT_W) ? r_data : i_wdata;
    assign o_strb = (r_state == WR_GOT_W) ? r_strb : i_wstrb;

    assign w_word = w_addr >> VGA_AXIL_ADDR_LSB;
    assign o_idx  = w_addr[VGA_AXIL_ADDR_LSB +: IDX_W];
    assign w_err  = (w_word >= axil_addr_t'(NUM_REGS)) || RO_MASK[o_idx];

    assign w_enter_resp = !i_srst &&
                          (((r_state == WR_IDLE) && w_aw_hs && w_w_hs) ||
                           ((r_state == WR_GOT_AW) && w_w_hs) ||
                           ((r_state == WR_GOT_W) && w_aw_hs));
    assign o_commit = w_enter_resp && !w_err;

    // NOTE: sequential state uses <= so every branch reads the pre-edge values.
    always_ff @(posedge clk) begin
        if (i_srst) begin
            r_state   <= WR_IDLE;
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_bvalid  <= 1'b0;
            r_bresp   <= AXIL_OKAY;
        end else if (w_enter_resp) begin
            r_state   <= WR_RESP;
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_bvalid  <= 1'b1;
            r_bresp   <= w_err ? AXIL_SLVERR : AXIL_OKAY;
        end else begin
            case (r_state)
                WR_IDLE: begin
                    if (w_aw_hs) begin
                        r_state   <= WR_GOT_AW;
                        r_awready <= 1'b0;
                        r_wready  <= 1'b1;
                    end else if (w_w_hs) begin
                        r_state   <= WR_GOT_W;
                        r_awready <= 1'b1;
                        r_wready  <= 1'b0;
                    end else begin
                        r_awready <= 1'b1;
                        r_wready  <= 1'b1;
                    end
                end
                WR_RESP: begin
                    if (i_bready) begin
                        r_state   <= WR_IDLE;
                        r_bvalid  <= 1'b0;
                        r_awready <= 1'b1;
                        r_wready  <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if ((r_state == WR_IDLE) && w_aw_hs) begin
            r_addr <= i_awaddr;
        end
        if ((r_state == WR_IDLE) && w_w_hs) begin
            r_data <= i_wdata;
            r_strb <= i_wstrb;
        end
    end

    assign o_awready = r_awready;
    assign o_wready  = r_wready;
    assign o_bvalid  = r_bvalid;
    assign o_bresp   = r_bresp;

endmodule

// File: rtl/vga_axil_regfile.sv
// AXI4-Lite VGA control/status register bank: RW registers with byte strobes,
// RO status slots fed from ro_data_i, per-register write pulses.
module vga_axil_regfile
    import vga_axil_pkg::*;
#(
    parameter int                  NUM_REGS = 4,
    parameter logic [NUM_REGS-1:0] RO_MASK  = 4'b1000
) (
    input  logic                      clk,
    input  logic                      srst,
    input  logic [31:0]               awaddr,
    input  logic                      awvalid,
    output logic                      awready,
    input  logic [31:0]               wdata,
    input  logic [3:0]                wstrb,
    input  logic                      wvalid,
    output logic                      wready,
    output logic [1:0]                bresp,
    output logic                      bvalid,
    input  logic                      bready,
    input  logic [31:0]               araddr,
    input  logic                      arvalid,
    output logic                      arready,
    output logic [31:0]               rdata,
    output logic [1:0]                rresp,
    output logic                      rvalid,
    input  logic                      rready,
    output logic [NUM_REGS*32-1:0]    regs_o,
    output logic [NUM_REGS-1:0]       wr_pulse_o,
    input  logic [NUM_REGS*32-1:0]    ro_data_i
);

    localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    axil_data_t          r_regs [NUM_REGS];
    logic [NUM_REGS-1:0] r_wr_pulse;
    logic                r_arready;
    logic                r_rvalid;
    axil_data_t          r_rdata;
    axil_resp_e          r_rresp;

    logic                w_commit;
    logic [IDX_W-1:0]    w_idx;
    axil_data_t          w_data;
    axil_strb_t          w_strb;
    axil_resp_e          w_bresp;
    logic                w_ar_hs;
    logic [IDX_W-1:0]    w_rd_idx;
    axil_addr_t          w_rd_word;
    axil_data_t          w_rd_data;
    axil_resp_e          w_rd_resp;

    vga_axil_slave_wr #(
        .NUM_REGS (NUM_REGS),
        .RO_MASK  (RO_MASK),
        .IDX_W    (IDX_W)
    ) u_wr (
        .clk       (clk),
        .i_srst    (srst),
        .i_awaddr  (awaddr),
        .i_awvalid (awvalid),
        .o_awready (awready),
        .i_wdata   (wdata),
        .i_wstrb   (wstrb),
        .i_wvalid  (wvalid),
        .o_wready  (wready),
        .o_bresp   (w_bresp),
        .o_bvalid  (bvalid),
        .i_bready  (bready),
        .o_commit  (w_commit),
        .o_idx     (w_idx),
        .o_data    (w_data),
        .o_strb    (w_strb)
    );

    assign bresp = w_bresp;

    // NOTE: the bank is only a few flops, so it is reset outright like any control register.
    always_ff @(posedge clk) begin
        if (srst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
            r_wr_pulse <= '0;
        end else begin
            r_wr_pulse <= '0;
            if (w_commit) begin
                r_wr_pulse[w_idx] <= 1'b1;
                for (int k = 0; k < AXIL_STRB_W; k++) begin
                    if (w_strb[k]) begin
                        r_regs[w_idx][8*k +: 8] <= w_data[8*k +: 8];
                    end
                end
            end
        end
    end

    assign w_ar_hs   = arvalid & r_arready;
    assign w_rd_idx  = araddr[VGA_AXIL_ADDR_LSB +: IDX_W];
    assign w_rd_word = araddr >> VGA_AXIL_ADDR_LSB;

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        w_rd_data = '0;
        w_rd_resp = AXIL_SLVERR;
        if (w_rd_word < axil_addr_t'(NUM_REGS)) begin
            w_rd_resp = AXIL_OKAY;
            w_rd_data = RO_MASK[w_rd_idx] ? ro_data_i[int'(w_rd_idx)*AXIL_DATA_W +: AXIL_DATA_W]
                                          : r_regs[w_rd_idx];
        end
    end

    // arready mirrors !rvalid, but stays low through reset.
    always_ff @(posedge clk) begin
        if (srst) begin
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rdata   <= '0;
            r_rresp   <= AXIL_OKAY;
        end else if (w_ar_hs) begin
            r_arready <= 1'b0;
            r_rvalid  <= 1'b1;
            r_rdata   <= w_rd_data;
            r_rresp   <= w_rd_resp;
        end else if (r_rvalid) begin
            if (rready) begin
                r_rvalid  <= 1'b0;
                r_arready <= 1'b1;
            end
        end else begin
            r_arready <= 1'b1;
        end
    end

    assign arready    = r_arready;
    assign rvalid     = r_rvalid;
    assign rdata      = r_rdata;
    assign rresp      = r_rresp;
    assign wr_pulse_o = r_wr_pulse;

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs_o
        assign regs_o[g*AXIL_DATA_W +: AXIL_DATA_W] = RO_MASK[g] ? '0 : r_regs[g];
    end

endmodule

// File: tb/tb_vga_axil_regfile.sv
// Directed bench for vga_axil_regfile: a vector table of single-beat writes/reads,
// then hand-written sequences for split handshakes, read backpressure, same-edge R/W and srst.
module tb_vga_axil_regfile;

    logic         clk = 1'b0;
    logic         srst;
    logic [31:0]  awaddr;
    logic         awvalid;
    logic         awready;
    logic [31:0]  wdata;
    logic [3:0]   wstrb;
    logic         wvalid;
    logic         wready;
    logic [1:0]   bresp;
    logic         bvalid;
    logic         bready;
    logic [31:0]  araddr;
    logic         arvalid;
    logic         arready;
    logic [31:0]  rdata;
    logic [1:0]   rresp;
    logic         rvalid;
    logic         rready;
    logic [127:0] regs_o;
    logic [3:0]   wr_pulse_o;
    logic [127:0] ro_data_i;

    int n_vec = 0;
    int n_err = 0;

    vga_axil_regfile dut (
        .clk        (clk),
        .srst       (srst),
        .awaddr     (awaddr),
        .awvalid    (awvalid),
        .awready    (awready),
        .wdata      (wdata),
        .wstrb      (wstrb),
        .wvalid     (wvalid),
        .wready     (wready),
        .bresp      (bresp),
        .bvalid     (bvalid),
        .bready     (bready),
        .araddr     (araddr),
        .arvalid    (arvalid),
        .arready    (arready),
        .rdata      (rdata),
        .rresp      (rresp),
        .rvalid     (rvalid),
        .rready     (rready),
        .regs_o     (regs_o),
        .wr_pulse_o (wr_pulse_o),
        .ro_data_i  (ro_data_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit           is_wr;
        logic [31:0]  addr;
        logic [31:0]  data;
        logic [3:0]   strb;
        logic [1:0]   resp;
        logic [31:0]  rdata;
        logic [3:0]   pulse;
        logic [127:0] regs;
    } vec_t;

    localparam int NV = 15;
    vec_t vecs [NV];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input string tag, input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s, input logic [1:0] er, input logic [3:0] ep,
                            input logic [127:0] eregs);
        check({tag, " awready idle"}, awready, 1);
        check({tag, " wready idle"}, wready, 1);
        awvalid = 1'b1; awaddr = a;
        wvalid  = 1'b1; wdata  = d; wstrb = s;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        check({tag, " bvalid"}, bvalid, 1);
        check({tag, " bresp"}, bresp, er);
        check({tag, " wr_pulse"}, wr_pulse_o, ep);
        check({tag, " regs_o"}, regs_o, eregs);
        check({tag, " awready resp"}, awready, 0);
        bready = 1'b1;
        tick();
        bready = 1'b0;
        check({tag, " bvalid drop"}, bvalid, 0);
        check({tag, " pulse drop"}, wr_pulse_o, 0);
    endtask

    task automatic do_read(input string tag, input logic [31:0] a, input logic [31:0] ed,
                           input logic [1:0] er);
        check({tag, " arready idle"}, arready, 1);
        arvalid = 1'b1; araddr = a;
        tick();
        arvalid = 1'b0;
        check({tag, " rvalid"}, rvalid, 1);
        check({tag, " rdata"}, rdata, ed);
        check({tag, " rresp"}, rresp, er);
        check({tag, " arready busy"}, arready, 0);
        rready = 1'b1;
        tick();
        rready = 1'b0;
        check({tag, " rvalid drop"}, rvalid, 0);
    endtask

    initial begin
        vecs[0]  = '{1'b1, 32'h4,        32'hDEADBEEF, 4'hF, 2'd0, 32'h0,        4'b0010, {32'h0, 32'h0,        32'hDEADBEEF, 32'h0}};
        vecs[1]  = '{1'b0, 32'h4,        32'h0,        4'h0, 2'd0, 32'hDEADBEEF, 4'b0000, {32'h0, 32'h0,        32'hDEADBEEF, 32'h0}};
        vecs[2]  = '{1'b1, 32'h0,        32'h11223344, 4'hF, 2'd0, 32'h0,        4'b0001, {32'h0, 32'h0,        32'hDEADBEEF, 32'h11223344}};
        vecs[3]  = '{1'b1, 32'h8,        32'h00000005, 4'hF, 2'd0, 32'h0,        4'b0100, {32'h0, 32'h5,        32'hDEADBEEF, 32'h11223344}};
        vecs[4]  = '{1'b1, 32'hA,        32'hFFFF0000, 4'hC, 2'd0, 32'h0,        4'b0100, {32'h0, 32'hFFFF0005, 32'hDEADBEEF, 32'h11223344}};
        vecs[5]  = '{1'b0, 32'hB,        32'h0,        4'h0, 2'd0, 32'hFFFF0005, 4'b0000, {32'h0, 32'hFFFF0005, 32'hDEADBEEF, 32'h11223344}};
        vecs[6]  = '{1'b1, 32'h4,        32'h0,        4'h0, 2'd0, 32'h0,        4'b0010, {32'h0, 32'hFFFF0005, 32'hDEADBEEF, 32'h11223344}};
        vecs[7]  = '{1'b0, 32'h4,        32'h0,        4'h0, 2'd0, 32'hDEADBEEF, 4'b0000, {32'h0, 32'hFFFF0005, 32'hDEADBEEF, 32'h11223344}};
        vecs[8]  = '{1'b1, 32'h10,       32'h00000001, 4'hF, 2'd2, 32'h0,        4'b0000, {32'h0, 32'hFFFF0005, 32'hDEADBEEF, 32'h11223344}};
        vecs[9]  = '{1'b1, 32'hC,        32'h12345678, 4'hF, 2'd2, 32'h0,        4'b0000, {32'h0, 32'hFFFF0005, 32'hDEADBEEF, 32'h11223344}};
        vecs[10] = '{1'b0, 32'h10,       32'h0,        4'h0, 2'd2, 32'h0,        4'b0000, {32'h0, 32'hFFFF0005, 32'hDEADBEEF, 32'h11223344}};
        vecs[11] = '{1'b0, 32'hC,        32'h0,        4'h0, 2'd0, 32'hCAFE0001, 4'b0000, {32'h0, 32'hFFFF0005, 32'hDEADBEEF, 32'h11223344}};
        vecs[12] = '{1'b0, 32'h0,        32'h0,        4'h0, 2'd0, 32'h11223344, 4'b0000, {32'h0, 32'hFFFF0005, 32'hDEADBEEF, 32'h11223344}};
        vecs[13] = '{1'b1, 32'h8,        32'h00000005, 4'hF, 2'd0, 32'h0,        4'b0100, {32'h0, 32'h5,        32'hDEADBEEF, 32'h11223344}};
        vecs[14] = '{1'b1, 32'h10000000, 32'h0000FFFF, 4'hF, 2'd2, 32'h0,        4'b0000, {32'h0, 32'h5,        32'hDEADBEEF, 32'h11223344}};

        srst    = 1'b1;
        awaddr  = '0; awvalid = 1'b0;
        wdata   = '0; wstrb   = '0; wvalid = 1'b0;
        bready  = 1'b0;
        araddr  = '0; arvalid = 1'b0; rready = 1'b0;
        ro_data_i = {32'hCAFE0001, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5};

        // Reset state
        repeat (3) tick();
        check("rst awready", awready, 0);
        check("rst wready", wready, 0);
        check("rst arready", arready, 0);
        check("rst bvalid", bvalid, 0);
        check("rst rvalid", rvalid, 0);
        check("rst regs_o", regs_o, 0);
        check("rst wr_pulse", wr_pulse_o, 0);
        srst = 1'b0;
        tick();
        check("post-rst awready", awready, 1);
        check("post-rst wready", wready, 1);
        check("post-rst arready", arready, 1);

        for (int i = 0; i < NV; i++) begin
            if (vecs[i].is_wr) begin
                do_write($sformatf("vec%0d wr", i), vecs[i].addr, vecs[i].data, vecs[i].strb,
                         vecs[i].resp, vecs[i].pulse, vecs[i].regs);
            end else begin
                do_read($sformatf("vec%0d rd", i), vecs[i].addr, vecs[i].rdata, vecs[i].resp);
                check($sformatf("vec%0d regs_o", i), regs_o, vecs[i].regs);
            end
        end

        // W two cycles ahead of AW, single-byte strobe into reg 0
        wvalid = 1'b1; wdata = 32'h000000AA; wstrb = 4'h1;
        tick();
        wvalid = 1'b0;
        check("gotw wready", wready, 0);
        check("gotw awready", awready, 1);
        check("gotw bvalid", bvalid, 0);
        tick();
        check("gotw2 wready", wready, 0);
        check("gotw2 awready", awready, 1);
        check("gotw2 pulse", wr_pulse_o, 0);
        awvalid = 1'b1; awaddr = 32'h0;
        tick();
        awvalid = 1'b0;
        check("gotw bvalid", bvalid, 1);
        check("gotw bresp", bresp, 0);
        check("gotw pulse", wr_pulse_o, 4'b0001);
        check("gotw regs_o", regs_o, {32'h0, 32'h5, 32'hDEADBEEF, 32'h112233AA});
        check("gotw resp awready", awready, 0);
        check("gotw resp wready", wready, 0);
        bready = 1'b1;
        tick();
        bready = 1'b0;
        check("gotw bvalid drop", bvalid, 0);

        // RO read held off by rready low for 5 cycles
        arvalid = 1'b1; araddr = 32'hC;
        tick();
        arvalid = 1'b0;
        ro_data_i[127:96] = 32'h0BAD0BAD;
        for (int c = 0; c < 5; c++) begin
            check($sformatf("hold%0d rvalid", c), rvalid, 1);
            check($sformatf("hold%0d rdata", c), rdata, 32'hCAFE0001);
            check($sformatf("hold%0d rresp", c), rresp, 0);
            check($sformatf("hold%0d arready", c), arready, 0);
            tick();
        end
        rready = 1'b1;
        tick();
        rready = 1'b0;
        ro_data_i[127:96] = 32'hCAFE0001;
        check("hold rvalid drop", rvalid, 0);
        check("hold arready back", arready, 1);

        // Same-edge AR and write commit to reg 2 (holds 0x5, new 0x9)
        awvalid = 1'b1; awaddr = 32'h8; wvalid = 1'b1; wdata = 32'h9; wstrb = 4'hF;
        arvalid = 1'b1; araddr = 32'h8;
        tick();
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        check("same-edge rdata", rdata, 32'h5);
        check("same-edge rvalid", rvalid, 1);
        check("same-edge bvalid", bvalid, 1);
        check("same-edge regs_o", regs_o, {32'h0, 32'h9, 32'hDEADBEEF, 32'h112233AA});
        bready = 1'b1; rready = 1'b1;
        tick();
        bready = 1'b0; rready = 1'b0;
        check("same-edge bvalid drop", bvalid, 0);
        check("same-edge rvalid drop", rvalid, 0);
        do_read("reread reg2", 32'h8, 32'h9, 2'd0);

        // srst while in GOT_AW, with a read also outstanding
        awvalid = 1'b1; awaddr = 32'h0;
        arvalid = 1'b1; araddr = 32'h4;
        tick();
        awvalid = 1'b0; arvalid = 1'b0;
        check("gotaw awready", awready, 0);
        check("gotaw wready", wready, 1);
        check("gotaw rvalid", rvalid, 1);
        srst = 1'b1; wvalid = 1'b1; wdata = 32'h0BAD0BAD; wstrb = 4'hF;
        tick();
        srst = 1'b0; wvalid = 1'b0;
        check("srst bvalid", bvalid, 0);
        check("srst rvalid", rvalid, 0);
        check("srst pulse", wr_pulse_o, 0);
        check("srst regs_o", regs_o, 0);
        check("srst awready", awready, 0);
        tick();
        check("srst pulse later", wr_pulse_o, 0);
        check("srst regs_o later", regs_o, 0);
        do_write("fresh wr", 32'h0, 32'h0000BEEF, 4'h3, 2'd0, 4'b0001,
                 {32'h0, 32'h0, 32'h0, 32'h0000BEEF});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
